// File: rtl/vending_pkg.sv
// Shared vending definitions: controller states, coin values, credit ceiling
// and the product price table.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHG_HI = 2'd2,
      CHG_LO = 2'd3
   } state_e;

   localparam logic [5:0] COIN_SMALL = 6'd1;
   localparam logic [5:0] COIN_LARGE = 6'd5;
   localparam logic [5:0] CREDIT_MAX = 6'd63;

   function automatic logic [5:0] price(input logic [2:0] code);
      logic [5:0] p;
      case (code)
         3'd1:    p = 6'd3;
         3'd2:    p = 6'd4;
         3'd3:    p = 6'd5;
         3'd4:    p = 6'd6;
         3'd5:    p = 6'd7;
         3'd6:    p = 6'd8;
         3'd7:    p = 6'd10;
         default: p = 6'd0;
      endcase
      return p;
   endfunction

   // Both strobes in one cycle are worth the sum of the two coins.
   function automatic logic [6:0] coin_value(input logic [1:0] strobe);
      logic [6:0] v;
      v = 7'd0;
      if (strobe[0]) v = v + {1'b0, COIN_SMALL};
      else           v = v + 7'd0;
      if (strobe[1]) v = v + {1'b0, COIN_LARGE};
      else           v = v + 7'd0;
      return v;
   endfunction

endpackage

// File: rtl/credit_manager_if.sv
// Bus between the vending FSM (master) and the credit manager (slave).
interface credit_manager_if;
   logic [1:0] sum;
   logic [2:0] sel;
   logic [2:0] boison;
   logic       cancel;
   logic       finish;
   logic [5:0] credit;
   logic       change5;
   logic       change1;
   logic       coin_reject;
   logic       busy;

   modport master (
      output sum, sel, boison, cancel,
      input  finish, credit, change5, change1, coin_reject, busy
   );

   modport slave (
      input  sum, sel, boison, cancel,
      output finish, credit, change5, change1, coin_reject, busy
   );
endinterface

// File: rtl/change_dispenser.sv
// Change sequencing: picks the coin denomination in CHG_HI, inserts the CHG_LO
// gap, and registers the change pulses for the cycle the controller is in CHG_HI.
module change_dispenser
   import vending_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  state_e     cur_state,
   input  logic [5:0] cur_credit,
   input  state_e     nxt_state,
   input  logic [5:0] nxt_credit,
   output state_e     next_state,
   output logic [5:0] debit,
   output logic       change5,
   output logic       change1
);

   logic change5_q, change5_d;
   logic change1_q, change1_d;

   // Sequencing decision from the current state and credit.
   always_comb begin
      next_state = cur_state;
      debit      = 6'd0;
      case (cur_state)
         CHG_HI: begin
            next_state = CHG_LO;
            if (cur_credit >= COIN_LARGE)  debit = COIN_LARGE;
            else if (cur_credit != 6'd0)   debit = COIN_SMALL;
            else                           debit = 6'd0;
         end
         CHG_LO: begin
            if (cur_credit != 6'd0) next_state = CHG_HI;
            else                    next_state = IDLE;
         end
         default: begin
            next_state = cur_state;
            debit      = 6'd0;
         end
      endcase
   end

   // Pulses are precomputed from the next state so they line up with CHG_HI.
   always_comb begin
      change5_d = (nxt_state == CHG_HI) && (nxt_credit >= COIN_LARGE);
      change1_d = (nxt_state == CHG_HI) && (nxt_credit <  COIN_LARGE);
   end

   // Pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         change5_q <= 1'b0;
         change1_q <= 1'b0;
      end else begin
         change5_q <= change5_d;
         change1_q <= change1_d;
      end
   end

   assign change5 = change5_q;
   assign change1 = change1_q;

endmodule

// File: rtl/credit_manager.sv
// Vending credit manager: accumulates coins, debits vends, and hands refunds
// to the change dispenser. Cancel beats dispense beats coin acceptance.
module credit_manager
   import vending_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   credit_manager_if.slave  bus
);

   state_e     state_q, state_d, dsp_next;
   logic [5:0] credit_q, credit_d;
   logic [5:0] dsp_debit, vend_price;
   logic [6:0] coin_sum;
   logic       coin_taken;
   logic       coin_reject_q, coin_reject_d;
   logic       busy_q, busy_d;
   logic       change5_s, change1_s;

   change_dispenser u_dispenser (
      .clk        (clk),
      .rst        (rst),
      .cur_state  (state_q),
      .cur_credit (credit_q),
      .nxt_state  (state_d),
      .nxt_credit (credit_d),
      .next_state (dsp_next),
      .debit      (dsp_debit),
      .change5    (change5_s),
      .change1    (change1_s)
   );

   // Next state, credit and reject flag.
   always_comb begin
      vend_price = price(bus.boison);
      coin_sum   = {1'b0, credit_q} + coin_value(bus.sum);
      state_d    = state_q;
      credit_d   = credit_q;
      coin_taken = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cancel && (credit_q != 6'd0)) begin
               state_d = CHG_HI;
            end else if ((bus.boison != 3'd0) && (credit_q >= vend_price)) begin
               credit_d = credit_q - vend_price;
               state_d  = VEND;
            end else if (coin_sum <= {1'b0, CREDIT_MAX}) begin
               credit_d   = coin_sum[5:0];
               coin_taken = 1'b1;
            end else begin
               coin_taken = 1'b0;
            end
         end
         VEND: begin
            if (credit_q != 6'd0) state_d = CHG_HI;
            else                  state_d = IDLE;
         end
         CHG_HI, CHG_LO: begin
            state_d  = dsp_next;
            credit_d = credit_q - dsp_debit;
         end
         default: state_d = IDLE;
      endcase
      coin_reject_d = (bus.sum != 2'b00) && !coin_taken;
      busy_d        = (state_d != IDLE);
   end

   // Controller state and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         credit_q      <= 6'd0;
         coin_reject_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         coin_reject_q <= coin_reject_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.finish      = (state_q == IDLE) && (bus.sel != 3'd0) &&
                            (credit_q >= price(bus.sel));
   assign bus.credit      = credit_q;
   assign bus.coin_reject = coin_reject_q;
   assign bus.busy        = busy_q;
   assign bus.change5     = change5_s;
   assign bus.change1     = change1_s;

endmodule

// File: doc/credit_manager.md
CREDIT_MANAGER -- requirements
Module: credit_manager

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sum, input, 2 bits: one-cycle coin strobes from the vending FSM; bit0 = 1-unit coin, bit1 = 5-unit coin.
REQ-004 SHALL have port sel, input, 3 bits: product selection, 0 = none.
REQ-005 SHALL have port boison, input, 3 bits: dispense strobe from the vending FSM; nonzero = product code being dispensed this cycle.
REQ-006 SHALL have port cancel, input, 1 bit: user refund request, level.
REQ-007 SHALL have port finish, output, 1 bit: credit covers price of sel.
REQ-008 SHALL have port credit, output, 6 bits: current credit in units.
REQ-009 SHALL have port change5 and change1, outputs, 1 bit each: one-cycle coin-return pulses.
REQ-010 SHALL have port coin_reject, output, 1 bit: one-cycle pulse when a coin strobe is not credited.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, VEND, CHG_HI, CHG_LO.
REQ-013 In IDLE, a nonzero sum SHALL add 1*sum[0] + 5*sum[1] (both set = 6) to credit on that edge if the result is <= 63; otherwise credit is unchanged and coin_reject pulses the next cycle.
REQ-014 Price table SHALL be sel 1..7 -> 3,4,5,6,7,8,10 units; sel 0 has no price.
REQ-015 finish SHALL be combinational from registered credit and sel: 1 iff state = IDLE, sel != 0, credit >= price(sel).
REQ-016 In IDLE, nonzero boison with credit >= price(boison) SHALL subtract the price on that edge and enter VEND; if credit < price, boison is ignored.
REQ-017 VEND SHALL last one cycle, then go to CHG_HI if credit > 0, else IDLE.
REQ-018 In IDLE, cancel with credit > 0 SHALL enter CHG_HI; with credit = 0, no action.
REQ-019 CHG_HI SHALL pulse change5 and subtract 5 if credit >= 5, else pulse change1 and subtract 1, then go to CHG_LO; exactly one change output high per CHG_HI cycle.
REQ-020 CHG_LO SHALL drive both change outputs low for one cycle, then go to CHG_HI if credit > 0, else IDLE.
REQ-021 Priority in IDLE, same cycle: cancel > boison > sum; any sum strobe not credited SHALL raise coin_reject.
REQ-022 Any nonzero sum in VEND, CHG_HI or CHG_LO SHALL be rejected (coin_reject pulse next cycle, credit unchanged).
REQ-023 boison and cancel outside IDLE SHALL be ignored.
REQ-024 Credit SHALL never underflow below 0 or exceed 63.

Reset
REQ-025 While rst = 0: state = IDLE, credit = 0, change5 = change1 = coin_reject = 0, busy = 0, finish = 0.
REQ-026 Reset asserted mid-change SHALL abort refund and clear credit; no further change pulses after release.

Structure
REQ-027 State enum, price table function, coin values (1, 5), CREDIT_MAX = 63 SHALL live in shared package vending_pkg.
REQ-028 Change sequencing (CHG_HI/CHG_LO, denomination choice) SHALL be one sub-module, change_dispenser; accumulation and vend logic stay in the top.

Verification
REQ-029 Reset, sum=01 x3, sel=1 -> credit 3, finish=1; sel=2 -> finish=0.
REQ-030 Credit 12, sel=3, boison=3 -> credit 7, VEND, then change5, gap, change1, gap, change1, IDLE, credit 0, busy low.
REQ-031 Credit 60, sum=10 -> coin_reject pulse, credit 60; sum=11 at credit 57 -> credit 63.
REQ-032 Credit 8, cancel and sum=10 same cycle -> coin_reject, refund change5, change1 x3, credit 0.
REQ-033 Credit 4, boison=3 -> ignored, credit 4; sum=01 during CHG_LO -> coin_reject, credit unchanged.
REQ-034 Refund of 11 started, rst low in second CHG_HI -> outputs 0, credit 0, no pulses after release.
